// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FSM state encoding, status bit indices and exponent bias helper
package fpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_e;

  localparam int ST_EXACT     = 0;
  localparam int ST_OVERFLOW  = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_INEXACT   = 3;

  function automatic int fpu_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fpu_round.sv
// rtl/fpu_round.sv - combinational rounding and one-hot status unit
// FPU_RNE_EN selects round-to-nearest-even; otherwise truncation toward zero
module fpu_round
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     sign_i,
  input  logic signed [EXP_W+1:0]  exp_i,
  input  logic [MAN_W+3:0]         man_i,
  input  logic                     zero_i,
  input  logic                     inf_i,
  output logic [EXP_W+MAN_W:0]     result_o,
  output logic [3:0]               status_o
);

  localparam logic signed [EXP_W+1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_W+1:0] EXP_ONE  = (EXP_W+2)'(1);

  logic                     inexact;
  logic                     round_up;
  logic [MAN_W+1:0]         man_r;
  logic [MAN_W-1:0]         frac;
  logic signed [EXP_W+1:0]  exp_r;

  // man_i layout: hidden, fraction, guard, round, sticky
  assign inexact = |man_i[2:0];

`ifdef FPU_RNE_EN
  assign round_up = man_i[2] & (man_i[1] | man_i[0] | man_i[3]);
`else
  assign round_up = 1'b0;
`endif

  assign man_r = {1'b0, man_i[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, round_up};

  always_comb begin
    exp_r    = exp_i;
    frac     = man_r[MAN_W-1:0];
    result_o = '0;
    status_o = '0;
    // Rounding carry out of the hidden bit renormalises by one
    if (man_r[MAN_W+1]) begin
      exp_r = exp_i + EXP_ONE;
      frac  = man_r[MAN_W:1];
    end
    if (inf_i || (exp_r >= EXP_MAX)) begin
      result_o              = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      status_o[ST_OVERFLOW] = 1'b1;
    end else if (zero_i) begin
      status_o[ST_EXACT] = 1'b1;
    end else if (exp_r <= EXP_ZERO) begin
      status_o[ST_UNDERFLOW] = 1'b1;
    end else begin
      result_o = {sign_i, exp_r[EXP_W-1:0], frac};
      if (inexact) status_o[ST_INEXACT] = 1'b1;
      else         status_o[ST_EXACT]   = 1'b1;
    end
  end

endmodule

// File: rtl/fpu_addsub_seq.sv
// rtl/fpu_addsub_seq.sv - multi-cycle FP add/sub with bit-serial align/normalise and start/busy/done handshake
// Rounding mode selected by FPU_RNE_EN (see fpu_round)
module fpu_addsub_seq
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                  clock100KHz,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic [EXP_W+MAN_W:0]  op_A_in,
  input  logic [EXP_W+MAN_W:0]  op_B_in,
  output logic                  busy,
  output logic                  done,
  output logic [EXP_W+MAN_W:0]  data_out,
  output logic [3:0]            status_out
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 4;
  localparam int DW = $clog2(MAN_W + 4);
  localparam logic signed [EXP_W+1:0] EXP_ONE = (EXP_W+2)'(1);

  state_e                   state_q;
  logic                     dec_ph_q;
  logic [W-1:0]             a_q, b_q;
  logic                     sign_q, eff_sub_q, inf_q, zero_q;
  logic signed [EXP_W+1:0]  exp_q;
  logic [MW-1:0]            ma_q, mb_q;
  logic [MW:0]              sum_q;
  logic [DW-1:0]            d_q;

  logic [EXP_W-1:0]         exp_a, exp_b, exp_diff;
  logic [MW-1:0]            man_a, man_b;
  logic [DW-1:0]            d_d;
  logic [MW:0]              add_d, norm_d;
  logic signed [EXP_W+1:0]  norm_exp_d;
  logic [W-1:0]             rnd_result;
  logic [3:0]               rnd_status;

  assign exp_a    = a_q[W-2:MAN_W];
  assign exp_b    = b_q[W-2:MAN_W];
  assign man_a    = {|exp_a, a_q[MAN_W-1:0], 3'b000};
  assign man_b    = {|exp_b, b_q[MAN_W-1:0], 3'b000};
  assign exp_diff = exp_a - exp_b;
  assign d_d      = (32'(exp_diff) > 32'(MAN_W + 3)) ? DW'(MAN_W + 3) : DW'(exp_diff);

  // A is the larger magnitude, so subtraction never borrows out
  assign add_d = eff_sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});

  always_comb begin
    if (sum_q[MW]) begin
      norm_d     = {1'b0, sum_q[MW:2], sum_q[1] | sum_q[0]};
      norm_exp_d = exp_q + EXP_ONE;
    end else begin
      norm_d     = {sum_q[MW-1:0], 1'b0};
      norm_exp_d = exp_q - EXP_ONE;
    end
  end

  fpu_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .sign_i   (sign_q),
    .exp_i    (exp_q),
    .man_i    (sum_q[MW-1:0]),
    .zero_i   (zero_q),
    .inf_i    (inf_q),
    .result_o (rnd_result),
    .status_o (rnd_status)
  );

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dec_ph_q   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      eff_sub_q  <= 1'b0;
      inf_q      <= 1'b0;
      zero_q     <= 1'b0;
      exp_q      <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      sum_q      <= '0;
      d_q        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q      <= op_A_in;
            b_q      <= {op_B_in[W-1] ^ op_sub, op_B_in[W-2:0]};
            dec_ph_q <= 1'b0;
            zero_q   <= 1'b0;
            busy     <= 1'b1;
            state_q  <= S_DECODE;
          end
        end
        // Two decode cycles: magnitude swap, then exponent difference and unpack
        S_DECODE: begin
          if (!dec_ph_q) begin
            if (b_q[W-2:0] > a_q[W-2:0]) begin
              a_q <= b_q;
              b_q <= a_q;
            end
            dec_ph_q <= 1'b1;
          end else begin
            sign_q    <= a_q[W-1];
            eff_sub_q <= a_q[W-1] ^ b_q[W-1];
            inf_q     <= (&exp_a) | (&exp_b);
            exp_q     <= {2'b00, exp_a};
            ma_q      <= man_a;
            mb_q      <= man_b;
            d_q       <= d_d;
            state_q   <= (d_d == '0) ? S_ADD : S_ALIGN;
          end
        end
        S_ALIGN: begin
          mb_q <= {1'b0, mb_q[MW-1:2], mb_q[1] | mb_q[0]};
          d_q  <= d_q - DW'(1);
          if (d_q == DW'(1)) state_q <= S_ADD;
        end
        S_ADD: begin
          sum_q <= add_d;
          if (add_d == '0) begin
            zero_q  <= 1'b1;
            state_q <= S_ROUND;
          end else if (add_d[MW] || !add_d[MW-1]) begin
            state_q <= S_NORM;
          end else begin
            state_q <= S_ROUND;
          end
        end
        S_NORM: begin
          sum_q <= norm_d;
          exp_q <= norm_exp_d;
          if (norm_d[MW-1]) state_q <= S_ROUND;
        end
        S_ROUND: begin
          data_out   <= rnd_result;
          status_out <= rnd_status;
          done       <= 1'b1;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// tb/tb_fpu_addsub_seq.sv - directed vector bench for fpu_addsub_seq (fp32 configuration)
module tb_fpu_addsub_seq;

  logic        clk = 1'b0;
  logic        reset, start, op_sub;
  logic [31:0] op_a, op_b, data_out;
  logic        busy, done;
  logic [3:0]  status_out;
  int          n_tests = 0;
  int          n_fail  = 0;

  localparam logic [3:0] EXACT = 4'b0001;
  localparam logic [3:0] OVF   = 4'b0010;
  localparam logic [3:0] UNF   = 4'b0100;
  localparam logic [3:0] INX   = 4'b1000;

  always #5 clk = ~clk;

  fpu_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clock100KHz (clk),
    .reset       (reset),
    .start       (start),
    .op_sub      (op_sub),
    .op_A_in     (op_a),
    .op_B_in     (op_b),
    .busy        (busy),
    .done        (done),
    .data_out    (data_out),
    .status_out  (status_out)
  );

  typedef struct {
    string       name;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  st;
    int          lat;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic sub, input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < 4 && busy; k++) @(negedge clk);
    @(negedge clk);
    start  = 1'b1;
    op_sub = sub;
    op_a   = a;
    op_b   = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    op_sub = ~sub;
    op_a   = 32'hDEADBEEF;
    op_b   = 32'h12345678;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
    end
  endtask

  initial begin
    int lat, dones, first;
    logic [31:0] got_data;
    logic [3:0]  got_st;

    vecs[0]  = '{"one_plus_one",   1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, EXACT, 5};
    vecs[1]  = '{"capped_align",   1'b0, 32'h3F800000, 32'h30800000, 32'h3F800000, INX,   30};
    vecs[2]  = '{"max_overflow",   1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, OVF,   5};
    vecs[3]  = '{"exact_cancel",   1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, EXACT, 4};
    vecs[4]  = '{"one_plus_half",  1'b0, 32'h3F800000, 32'h3F000000, 32'h3FC00000, EXACT, 5};
    vecs[5]  = '{"two_minus_1p5",  1'b1, 32'h40000000, 32'h3FC00000, 32'h3F000000, EXACT, 7};
    vecs[6]  = '{"swap_neg",       1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000, EXACT, 6};
    vecs[7]  = '{"guard_tie",      1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, INX,   28};
`ifdef FPU_RNE_EN
    vecs[8]  = '{"round_gr",       1'b0, 32'h3F800001, 32'h33C00000, 32'h3F800002, INX,   28};
`else
    vecs[8]  = '{"round_gr",       1'b0, 32'h3F800001, 32'h33C00000, 32'h3F800001, INX,   28};
`endif
    vecs[9]  = '{"inf_operand",    1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, OVF,   30};
    vecs[10] = '{"zero_operand",   1'b0, 32'h00000000, 32'h3F800000, 32'h3F800000, EXACT, 30};
    vecs[11] = '{"zero_zero",      1'b0, 32'h00000000, 32'h00000000, 32'h00000000, EXACT, 4};
    vecs[12] = '{"neg_plus_neg",   1'b0, 32'hBF800000, 32'hBF800000, 32'hC0000000, EXACT, 5};

    reset  = 1'b1;
    start  = 1'b0;
    op_sub = 1'b0;
    op_a   = '0;
    op_b   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   32'(busy),       32'd0);
    check("rst_done",   32'(done),       32'd0);
    check("rst_data",   data_out,        32'd0);
    check("rst_status", 32'(status_out), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].sub, vecs[i].a, vecs[i].b);
      wait_done(lat);
      check({vecs[i].name, "_lat"},    32'(lat),        32'(vecs[i].lat));
      check({vecs[i].name, "_data"},   data_out,        vecs[i].res);
      check({vecs[i].name, "_status"}, 32'(status_out), 32'(vecs[i].st));
      @(posedge clk);
      #1;
      check({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
      check({vecs[i].name, "_idle"},       32'(busy), 32'd0);
    end

    // Reset in the middle of a long alignment discards the operation
    issue(1'b0, 32'h3F800000, 32'h30800000);
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_busy",   32'(busy),       32'd0);
    check("mid_rst_data",   data_out,        32'd0);
    check("mid_rst_status", 32'(status_out), 32'd0);
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("mid_rst_discard", 32'(dones), 32'd0);

    // Underflow with a stray start pulse while busy
    issue(1'b1, 32'h00C00000, 32'h00800000);
    dones    = 0;
    first    = 0;
    got_data = 32'hFFFFFFFF;
    got_st   = 4'hF;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        start  = 1'b1;
        op_sub = 1'b0;
        op_a   = 32'h3F800000;
        op_b   = 32'h3F800000;
      end
      if (k == 3) start = 1'b0;
      if (done) begin
        dones++;
        if (first == 0) begin
          first    = k;
          got_data = data_out;
          got_st   = status_out;
        end
      end
    end
    check("unf_dones",  32'(dones),  32'd1);
    check("unf_lat",    32'(first),  32'd5);
    check("unf_data",   got_data,    32'd0);
    check("unf_status", 32'(got_st), 32'(UNF));

    // Back-to-back: start held through DONE is only taken once IDLE
    issue(1'b0, 32'h3F800000, 32'h3F800000);
    wait_done(lat);
    check("b2b_first_lat", 32'(lat), 32'd5);
    start  = 1'b1;
    op_sub = 1'b0;
    op_a   = 32'h3F800000;
    op_b   = 32'h3F000000;
    @(posedge clk);
    #1;
    check("b2b_no_accept_in_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_accept_in_idle", 32'(busy), 32'd1);
    wait_done(lat);
    check("b2b_second_lat",    32'(lat),        32'd5);
    check("b2b_second_data",   data_out,        32'h3FC00000);
    check("b2b_second_status", 32'(status_out), 32'(EXACT));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
